// File: rtl/lock_pkg.sv
// Shared types and helpers for the combination-lock access controller.
package lock_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ENTRY   = 3'd1,
      CHECK   = 3'd2,
      OPEN    = 3'd3,
      LOCKOUT = 3'd4
   } lock_state_t;

   // Counter width able to hold the longer of the two timed phases.
   function automatic int timer_width(input int unlock_cycles, input int lockout_cycles);
      int longest;
      longest = (unlock_cycles > lockout_cycles) ? unlock_cycles : lockout_cycles;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done flags the final cycle of a loaded interval.
module lock_timer #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clear,
   output logic             done
);

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (load) begin
         count_next = load_val;
      end else if (clear) begin
         count_next = '0;
      end else if (count_reg != '0) begin
         count_next = count_reg - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   // A value of 1 is the last cycle of the interval; 0 also reads as done
   // so a timed state can never stall on an empty counter.
   assign done = (count_reg <= WIDTH'(1));

endmodule

// File: rtl/lock_access_ctrl.sv
// Serial combination-lock sequencer: collects framed entry bits, compares
// against the programmable code, then opens or counts toward a timed lockout.
module lock_access_ctrl
   import lock_pkg::*;
#(
   parameter int                  CODE_LEN       = 5,
   parameter logic [CODE_LEN-1:0] CODE_INIT      = 5'b01001,
   parameter int                  MAX_FAILS      = 3,
   parameter int                  UNLOCK_CYCLES  = 8,
   parameter int                  LOCKOUT_CYCLES = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           bit_valid,
   input  logic                           bit_in,
   input  logic                           abort,
   input  logic                           relock,
   input  logic                           prog_we,
   input  logic [CODE_LEN-1:0]            prog_code,
   output logic                           unlock,
   output logic                           locked_out,
   output logic                           ready,
   output logic                           pass_pulse,
   output logic                           fail_pulse,
   output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

   localparam int BW = $clog2(CODE_LEN + 1);
   localparam int FW = $clog2(MAX_FAILS + 1);
   localparam int TW = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);

   localparam logic [BW-1:0] LAST_BIT    = BW'(CODE_LEN - 1);
   localparam logic [FW-1:0] FAIL_LAST   = FW'(MAX_FAILS - 1);
   localparam logic [FW-1:0] FAIL_SAT    = FW'(MAX_FAILS);
   localparam logic [TW-1:0] UNLOCK_VAL  = TW'(UNLOCK_CYCLES);
   localparam logic [TW-1:0] LOCKOUT_VAL = TW'(LOCKOUT_CYCLES);

   lock_state_t         state_reg,    state_next;
   logic [CODE_LEN-1:0] shift_reg,    shift_next;
   logic [CODE_LEN-1:0] code_reg,     code_next;
   logic [BW-1:0]       bit_cnt_reg,  bit_cnt_next;
   logic [FW-1:0]       fail_cnt_reg, fail_cnt_next;
   logic                pass_reg,     pass_next;
   logic                fail_reg,     fail_next;

   logic          timer_load;
   logic          timer_clear;
   logic [TW-1:0] timer_val;
   logic          timer_done;

   lock_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_val),
      .clear    (timer_clear),
      .done     (timer_done)
   );

   always_comb begin
      state_next    = state_reg;
      shift_next    = shift_reg;
      code_next     = code_reg;
      bit_cnt_next  = bit_cnt_reg;
      fail_cnt_next = fail_cnt_reg;
      pass_next     = 1'b0;
      fail_next     = 1'b0;
      timer_load    = 1'b0;
      timer_clear   = 1'b0;
      timer_val     = UNLOCK_VAL;

      case (state_reg)
         IDLE: begin
            if (bit_valid) begin
               shift_next   = {shift_reg[CODE_LEN-2:0], bit_in};
               bit_cnt_next = BW'(1);
               state_next   = ENTRY;
            end
         end
         ENTRY: begin
            // abort takes priority over a bit arriving in the same cycle
            if (abort) begin
               bit_cnt_next = '0;
               state_next   = IDLE;
            end else if (bit_valid) begin
               shift_next   = {shift_reg[CODE_LEN-2:0], bit_in};
               bit_cnt_next = bit_cnt_reg + BW'(1);
               if (bit_cnt_reg == LAST_BIT) begin
                  state_next = CHECK;
               end
            end
         end
         CHECK: begin
            bit_cnt_next = '0;
            if (shift_reg == code_reg) begin
               state_next    = OPEN;
               timer_load    = 1'b1;
               timer_val     = UNLOCK_VAL;
               fail_cnt_next = '0;
               pass_next     = 1'b1;
            end else begin
               fail_next = 1'b1;
               if (fail_cnt_reg >= FAIL_LAST) begin
                  fail_cnt_next = FAIL_SAT;
                  state_next    = LOCKOUT;
                  timer_load    = 1'b1;
                  timer_val     = LOCKOUT_VAL;
               end else begin
                  fail_cnt_next = fail_cnt_reg + FW'(1);
                  state_next    = IDLE;
               end
            end
         end
         OPEN: begin
            if (prog_we) begin
               code_next = prog_code;
            end
            if (relock) begin
               state_next  = IDLE;
               timer_clear = 1'b1;
            end else if (timer_done) begin
               state_next = IDLE;
            end
         end
         LOCKOUT: begin
            if (timer_done) begin
               state_next    = IDLE;
               fail_cnt_next = '0;
            end
         end
         default: begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            timer_clear  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         shift_reg    <= '0;
         code_reg     <= CODE_INIT;
         bit_cnt_reg  <= '0;
         fail_cnt_reg <= '0;
         pass_reg     <= 1'b0;
         fail_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         code_reg     <= code_next;
         bit_cnt_reg  <= bit_cnt_next;
         fail_cnt_reg <= fail_cnt_next;
         pass_reg     <= pass_next;
         fail_reg     <= fail_next;
      end
   end

   assign unlock     = (state_reg == OPEN);
   assign locked_out = (state_reg == LOCKOUT);
   assign ready      = (state_reg == IDLE) || (state_reg == ENTRY);
   assign pass_pulse = pass_reg;
   assign fail_pulse = fail_reg;
   assign fail_cnt   = fail_cnt_reg;

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Directed and randomized stimulus for lock_access_ctrl, checked every cycle
// against an attempt-level reference model.
module tb_lock_access_ctrl;

   localparam int UNLOCK_N  = 8;
   localparam int LOCKOUT_N = 16;
   localparam int MAXF      = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       bit_valid = 1'b0;
   logic       bit_in = 1'b0;
   logic       abort = 1'b0;
   logic       relock = 1'b0;
   logic       prog_we = 1'b0;
   logic [4:0] prog_code = 5'd0;
   logic       unlock, locked_out, ready, pass_pulse, fail_pulse;
   logic [1:0] fail_cnt;

   int checks = 0;
   int errors = 0;

   // reference model: pending entry bits plus remaining-time counters
   bit         m_q[$];
   bit         m_check;
   int         m_open, m_lock, m_fails;
   logic [4:0] m_code;
   bit         m_pass, m_fail;
   bit         plan[$];

   always #5 clk = ~clk;

   lock_access_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .abort      (abort),
      .relock     (relock),
      .prog_we    (prog_we),
      .prog_code  (prog_code),
      .unlock     (unlock),
      .locked_out (locked_out),
      .ready      (ready),
      .pass_pulse (pass_pulse),
      .fail_pulse (fail_pulse),
      .fail_cnt   (fail_cnt)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      m_check = 0;
      m_open  = 0;
      m_lock  = 0;
      m_fails = 0;
      m_code  = 5'b01001;
      m_pass  = 0;
      m_fail  = 0;
   endfunction

   function automatic bit model_ready();
      return !(m_check || m_open > 0 || m_lock > 0);
   endfunction

   function automatic void model_step(input bit bv, input bit bi, input bit ab,
                                      input bit rl, input bit pw, input logic [4:0] pc);
      logic [4:0] v;
      m_pass = 0;
      m_fail = 0;
      if (m_check) begin
         v = '0;
         foreach (m_q[i]) v = {v[3:0], m_q[i]};
         m_q.delete();
         m_check = 0;
         if (v == m_code) begin
            m_open  = UNLOCK_N;
            m_fails = 0;
            m_pass  = 1;
         end else begin
            m_fail  = 1;
            m_fails = m_fails + 1;
            if (m_fails >= MAXF) begin
               m_fails = MAXF;
               m_lock  = LOCKOUT_N;
            end
         end
      end else if (m_open > 0) begin
         if (pw) m_code = pc;
         if (rl) m_open = 0;
         else    m_open = m_open - 1;
      end else if (m_lock > 0) begin
         m_lock = m_lock - 1;
         if (m_lock == 0) m_fails = 0;
      end else begin
         if (m_q.size() > 0 && ab) begin
            m_q.delete();
         end else if (bv) begin
            m_q.push_back(bi);
            if (m_q.size() == 5) m_check = 1;
         end
      end
   endfunction

   task automatic compare_outs();
      logic [7:0] exp, got;
      exp = {1'b0, m_open > 0, m_lock > 0, model_ready(), m_pass, m_fail, 2'(m_fails)};
      got = {1'b0, unlock, locked_out, ready, pass_pulse, fail_pulse, fail_cnt};
      check_val("outs{unl,lko,rdy,pass,fail,cnt}", 32'(got), 32'(exp));
      if (m_pass || m_fail)
         $display("attempt %s fail_cnt=%0d t=%0t", m_pass ? "pass" : "reject", fail_cnt, $time);
   endtask

   task automatic step(input bit bv, input bit bi, input bit ab,
                       input bit rl, input bit pw, input logic [4:0] pc);
      bit_valid = bv; bit_in = bi; abort = ab; relock = rl; prog_we = pw; prog_code = pc;
      @(posedge clk);
      model_step(bv, bi, ab, rl, pw, pc);
      @(negedge clk);
      compare_outs();
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 5'd0);
   endtask

   task automatic enter(input logic [4:0] v, input int max_gap);
      for (int i = 4; i >= 0; i--) begin
         step(1, v[i], 0, 0, 0, 5'd0);
         if (i > 0 && max_gap > 0) idle($urandom_range(max_gap, 0));
      end
   endtask

   initial begin
      int un;
      int lk;
      bit bv, bi, ab, rl, pw;
      logic [4:0] pc;

      // reset state
      model_reset();
      repeat (2) @(negedge clk);
      check_val("rst_ready", 32'(ready), 32'd1);
      check_val("rst_unlock", 32'(unlock), 32'd0);
      compare_outs();
      reset = 1'b1;

      // 1: correct code, unlock for exactly UNLOCK_N cycles
      enter(5'b01001, 0);
      un = 0;
      for (int i = 0; i < 12; i++) begin idle(1); if (unlock) un++; end
      check_val("t1_unlock_len", 32'(un), 32'(UNLOCK_N));

      // 2: three wrong attempts, lockout with ignored bit activity
      for (int a = 0; a < 3; a++) begin
         enter(5'b11111, 0);
         if (a < 2) idle(2);
      end
      lk = 0;
      for (int i = 0; i < 20; i++) begin
         step($urandom_range(1, 0), $urandom_range(1, 0), 0, 0, 0, 5'd0);
         if (locked_out) lk++;
      end
      check_val("t2_lockout_len", 32'(lk), 32'(LOCKOUT_N));
      check_val("t2_fail_cnt", 32'(fail_cnt), 32'd0);

      // 3: abort discards a partial attempt without a reject
      enter(5'b11111, 0); idle(2);
      step(1, 0, 0, 0, 0, 5'd0); step(1, 1, 0, 0, 0, 5'd0); step(1, 0, 0, 0, 0, 5'd0);
      step(0, 0, 1, 0, 0, 5'd0);
      enter(5'b01001, 2);
      un = 0;
      for (int i = 0; i < 10; i++) begin idle(1); if (unlock) un++; end
      check_val("t3_unlocked", 32'(un), 32'(UNLOCK_N));
      check_val("t3_fail_cnt", 32'(fail_cnt), 32'd0);

      // 4: reprogramming only while open
      step(0, 0, 0, 0, 1, 5'b10110);
      enter(5'b01001, 0); idle(3);
      step(0, 0, 0, 1, 1, 5'b10110);
      check_val("t4_relock_ready", 32'(ready), 32'd1);
      enter(5'b01001, 0); idle(2);
      check_val("t4_old_code_rejected", 32'(fail_cnt), 32'd1);
      enter(5'b10110, 0); idle(1);
      check_val("t4_new_code_unlock", 32'(unlock), 32'd1);
      idle(10);

      // 5: asynchronous reset during lockout
      for (int a = 0; a < 3; a++) begin enter(5'b00000, 0); if (a < 2) idle(2); end
      idle(6);
      check_val("t5_in_lockout", 32'(locked_out), 32'd1);
      reset = 1'b0;
      #1;
      check_val("t5_async_lko", 32'(locked_out), 32'd0);
      check_val("t5_async_ready", 32'(ready), 32'd1);
      check_val("t5_async_cnt", 32'(fail_cnt), 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      enter(5'b01001, 0); idle(1);
      check_val("t5_init_code", 32'(unlock), 32'd1);
      idle(10);

      // 6: early relock on the third open cycle; abort beats a bit
      enter(5'b01001, 0);
      un = 0;
      for (int i = 1; i <= 6; i++) begin step(0, 0, 0, i == 4, 0, 5'd0); if (unlock) un++; end
      check_val("t6_relock_len", 32'(un), 32'd3);
      step(1, 0, 0, 0, 0, 5'd0); step(1, 1, 0, 0, 0, 5'd0); step(1, 1, 1, 0, 0, 5'd0);
      enter(5'b01001, 0); idle(1);
      check_val("t6_abort_cleared", 32'(unlock), 32'd1);
      idle(10);

      // randomized traffic
      plan.delete();
      for (int n = 0; n < 1500; n++) begin
         bv = ($urandom_range(9, 0) < 6);
         bi = 0;
         if (bv && model_ready()) begin
            if (plan.size() == 0) begin
               pc = ($urandom_range(1, 0) == 1) ? m_code : 5'($urandom);
               for (int i = 4; i >= 0; i--) plan.push_back(pc[i]);
            end
            bi = plan.pop_front();
         end else if (bv) begin
            bi = 1'($urandom);
         end
         ab = !bv && ($urandom_range(24, 0) == 0);
         if (ab) plan.delete();
         rl = ($urandom_range(11, 0) == 0);
         pw = ($urandom_range(19, 0) == 0);
         pc = 5'($urandom);
         step(bv, bi, ab, rl, pw, pc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
